// File: rtl/lcd_seq_pkg.sv
// Shared definitions for the LCD score sequencer: FSM states,
// step indices, HD44780 command bytes, ASCII glyphs and digit helper.
package lcd_seq_pkg;

   typedef enum logic [1:0] {
      ISSUE = 2'd0,
      WAIT  = 2'd1,
      IDLE  = 2'd2
   } state_t;

   localparam logic [3:0] INIT_LAST = 4'd3;
   localparam logic [3:0] HOME      = 4'd4;
   localparam logic [3:0] LAST      = 4'd13;

   localparam logic [7:0] CMD_FUNCSET = 8'h38;
   localparam logic [7:0] CMD_DISPON  = 8'h0C;
   localparam logic [7:0] CMD_CLEAR   = 8'h01;
   localparam logic [7:0] CMD_ENTRY   = 8'h06;
   localparam logic [7:0] CMD_HOME    = 8'h80;

   localparam logic [7:0] ASCII_P     = 8'h50;
   localparam logic [7:0] ASCII_1     = 8'h31;
   localparam logic [7:0] ASCII_2     = 8'h32;
   localparam logic [7:0] ASCII_COLON = 8'h3A;
   localparam logic [7:0] ASCII_SPACE = 8'h20;
   localparam logic [7:0] ASCII_ZERO  = 8'h30;
   localparam logic [7:0] ASCII_NINE  = 8'h39;

   // Scores above 9 saturate to the glyph '9'.
   function automatic logic [7:0] score_digit(input logic [3:0] s);
      if (s > 4'd9)
         return ASCII_NINE;
      return ASCII_ZERO + {4'd0, s};
   endfunction

endpackage

// File: rtl/lcd_score_rom.sv
// Byte table for the sequencer: maps a step index to {rs, data}.
// Ports: step, digitA, digitB in; rs (0=cmd, 1=data), data out.
module lcd_score_rom
   import lcd_seq_pkg::*;
(
   input  logic [3:0] step,
   input  logic [7:0] digitA,
   input  logic [7:0] digitB,
   output logic       rs,
   output logic [7:0] data
);

   always_comb begin
      rs   = (step > HOME) && (step <= LAST);
      data = 8'h00;
      unique case (step)
         4'd0:    data = CMD_FUNCSET;
         4'd1:    data = CMD_DISPON;
         4'd2:    data = CMD_CLEAR;
         INIT_LAST: data = CMD_ENTRY;
         HOME:    data = CMD_HOME;
         4'd5:    data = ASCII_P;
         4'd6:    data = ASCII_1;
         4'd7:    data = ASCII_COLON;
         4'd8:    data = digitA;
         4'd9:    data = ASCII_SPACE;
         4'd10:   data = ASCII_P;
         4'd11:   data = ASCII_2;
         4'd12:   data = ASCII_COLON;
         LAST:    data = digitB;
         default: data = 8'h00;
      endcase
   end

endmodule

// File: rtl/lcd_score_sequencer.sv
// Drives the LCD write unit: init commands, then "P1:a P2:b" per redraw.
// Ports: Clock, Reset, ScoreA/B, Update, LcdDone in; LcdStart, LcdRS,
// LcdData, Busy, Error out. TIMEOUT sets the lost-transaction limit.
module lcd_score_sequencer
   import lcd_seq_pkg::*;
#(
   parameter int TIMEOUT = 300000
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic [3:0] ScoreA,
   input  logic [3:0] ScoreB,
   input  logic       Update,
   input  logic       LcdDone,
   output logic       LcdStart,
   output logic       LcdRS,
   output logic [7:0] LcdData,
   output logic       Busy,
   output logic       Error
);

   localparam logic [19:0] CNT_LAST = 20'(TIMEOUT - 1);

   state_t      state, state_n;
   logic [3:0]  step, step_n;
   logic        pending, pending_n;
   logic [19:0] cnt, cnt_n;
   logic        err_n;
   logic        snap;
   logic [7:0]  dig_a, dig_b;
   logic        rs_q;
   logic [7:0]  data_q;
   logic        rom_rs;
   logic [7:0]  rom_data;
   logic        issue;

   lcd_score_rom u_rom (
      .step   (step),
      .digitA (dig_a),
      .digitB (dig_b),
      .rs     (rom_rs),
      .data   (rom_data)
   );

   // Reset forces ISSUE, so the strobe is masked while Reset is held.
   assign issue    = (state == ISSUE) && !Reset;
   assign LcdStart = issue;
   assign LcdRS    = issue ? rom_rs   : rs_q;
   assign LcdData  = issue ? rom_data : data_q;

   always_comb begin
      state_n   = state;
      step_n    = step;
      pending_n = pending;
      cnt_n     = cnt;
      err_n     = Error;
      unique case (state)
         ISSUE: begin
            state_n = WAIT;
            cnt_n   = '0;
         end
         WAIT: begin
            // Completion beats a coincident timeout.
            if (LcdDone) begin
               if (step == LAST) begin
                  state_n = IDLE;
               end else begin
                  step_n  = step + 4'd1;
                  state_n = ISSUE;
               end
            end else if (cnt == CNT_LAST) begin
               err_n   = 1'b1;
               step_n  = '0;
               state_n = ISSUE;
            end else begin
               cnt_n = cnt + 20'd1;
            end
         end
         IDLE: begin
            if (Update || pending) begin
               step_n    = HOME;
               state_n   = ISSUE;
               pending_n = 1'b0;
            end
         end
         default: state_n = ISSUE;
      endcase
      if (state != IDLE && Update)
         pending_n = 1'b1;
   end

   // Step HOME is only ever entered from another step value.
   assign snap = (step_n == HOME) && (step != HOME);

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state   <= ISSUE;
         step    <= '0;
         pending <= 1'b0;
         cnt     <= '0;
         Error   <= 1'b0;
         Busy    <= 1'b1;
         rs_q    <= 1'b0;
         data_q  <= 8'h00;
         dig_a   <= ASCII_ZERO;
         dig_b   <= ASCII_ZERO;
      end else begin
         state   <= state_n;
         step    <= step_n;
         pending <= pending_n;
         cnt     <= cnt_n;
         Error   <= err_n;
         Busy    <= (state_n != IDLE);
         if (snap) begin
            dig_a <= score_digit(ScoreA);
            dig_b <= score_digit(ScoreB);
         end
         if (state == ISSUE) begin
            rs_q   <= rom_rs;
            data_q <= rom_data;
         end
      end
   end

endmodule

// File: tb/tb_lcd_score_sequencer.sv
// Scoreboard bench for lcd_score_sequencer with an LCD write-unit model.
// Expected bytes are queued by stimulus and popped on every LcdStart.
module tb_lcd_score_sequencer;

   localparam int TO = 50;

   logic       Clock = 1'b0;
   logic       Reset = 1'b1;
   logic [3:0] ScoreA = 4'd0;
   logic [3:0] ScoreB = 4'd0;
   logic       Update = 1'b0;
   logic       done_model = 1'b0;
   logic       done_force = 1'b0;
   logic       LcdDone;
   logic       LcdStart;
   logic       LcdRS;
   logic [7:0] LcdData;
   logic       Busy;
   logic       Error;

   assign LcdDone = done_model | done_force;

   lcd_score_sequencer #(.TIMEOUT(TO)) dut (
      .Clock    (Clock),
      .Reset    (Reset),
      .ScoreA   (ScoreA),
      .ScoreB   (ScoreB),
      .Update   (Update),
      .LcdDone  (LcdDone),
      .LcdStart (LcdStart),
      .LcdRS    (LcdRS),
      .LcdData  (LcdData),
      .Busy     (Busy),
      .Error    (Error)
   );

   always #10 Clock = ~Clock;

   int cyc = 0;
   always @(posedge Clock) cyc++;

   int checks = 0;
   int errors = 0;
   logic [8:0] exp_q[$];
   logic [8:0] e;
   int n_starts = 0;
   int home_cyc = -1;
   int last_done_cyc = -1;
   int lcd_delay = 10;
   int cd = 0;

   // LCD write unit: Done lcd_delay cycles after Start; 0 = never.
   always @(negedge Clock) begin
      done_model = 1'b0;
      if (Reset) begin
         cd = 0;
      end else if (cd != 0) begin
         cd--;
         if (cd == 0) begin
            done_model = 1'b1;
            last_done_cyc = cyc;
         end
      end
      if (LcdStart && lcd_delay != 0)
         cd = lcd_delay;
   end

   // Monitor: every Start must match the head of the expected queue.
   always @(negedge Clock) begin
      if (!Reset && LcdStart) begin
         n_starts++;
         if ({LcdRS, LcdData} == 9'h080)
            home_cyc = cyc;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL start_extra: got rs=%0b data=%02h, none expected",
                     LcdRS, LcdData);
         end else begin
            e = exp_q.pop_front();
            if ({LcdRS, LcdData} !== e) begin
               errors++;
               $display("FAIL start_byte: got rs=%0b data=%02h, want rs=%0b data=%02h",
                        LcdRS, LcdData, e[8], e[7:0]);
            end
         end
      end
   end

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %0h, want %0h", nm, act, want);
      end
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   function automatic logic [7:0] dig(input int s);
      return 8'h30 + 8'(s > 9 ? 9 : s);
   endfunction

   task automatic push_init();
      exp_q.push_back({1'b0, 8'h38});
      exp_q.push_back({1'b0, 8'h0C});
      exp_q.push_back({1'b0, 8'h01});
      exp_q.push_back({1'b0, 8'h06});
   endtask

   task automatic push_line(input int a, input int b);
      logic [7:0] ln [9];
      ln = '{8'h50, 8'h31, 8'h3A, dig(a), 8'h20,
             8'h50, 8'h32, 8'h3A, dig(b)};
      exp_q.push_back({1'b0, 8'h80});
      foreach (ln[i])
         exp_q.push_back({1'b1, ln[i]});
   endtask

   task automatic pulse_update(output int q);
      tick();
      q = cyc;
      Update = 1'b1;
      tick();
      Update = 1'b0;
   endtask

   task automatic wait_idle(input string nm, output int at);
      int n = 0;
      do begin
         @(negedge Clock);
         #1;
         n++;
      end while (!(Busy == 1'b0 && exp_q.size() == 0) && n < 3000);
      at = cyc;
      checks++;
      if (n >= 3000) begin
         errors++;
         $display("FAIL %s: no idle, queue left %0d, want 0",
                  nm, exp_q.size());
      end
   endtask

   task automatic wait_starts(input int target, input string nm);
      int n = 0;
      while (n_starts < target && n < 2000) begin
         @(negedge Clock);
         #1;
         n++;
      end
      check(nm, n_starts, target);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int base, q, at, a, b, k;

      // Reset and power-on sequence
      ScoreA = 4'd3;
      ScoreB = 4'd0;
      repeat (3) begin
         @(negedge Clock);
         check("rst_start", LcdStart, 0);
         check("rst_rs", LcdRS, 0);
         check("rst_data", LcdData, 8'h00);
         check("rst_error", Error, 0);
         check("rst_busy", Busy, 1);
      end
      push_init();
      push_line(3, 0);
      base = n_starts;
      tick();
      Reset = 1'b0;
      @(negedge Clock);
      check("first_start", LcdStart, 1);
      check("first_data", LcdData, 8'h38);
      wait_idle("init_seq", at);
      check("init_count", n_starts - base, 14);
      check("busy_fall", at, last_done_cyc + 1);
      check("init_error", Error, 0);

      // Update in IDLE: HOME next cycle, digits 7 and saturated 9
      ScoreA = 4'd7;
      ScoreB = 4'd12;
      push_line(7, 12);
      base = n_starts;
      pulse_update(q);
      @(negedge Clock);
      #1;
      check("upd_latency", home_cyc, q + 1);
      wait_idle("redraw", at);
      check("redraw_count", n_starts - base, 10);

      // Updates while busy collapse; current line keeps its snapshot
      b = $urandom_range(0, 15);
      ScoreB = 4'(b);
      push_line(7, b);
      base = n_starts;
      pulse_update(q);
      wait_starts(base + 3, "reach_step7");
      pulse_update(q);
      ScoreA = 4'd8;
      push_line(8, b);
      tick();
      pulse_update(q);
      pulse_update(q);
      k = 0;
      do begin
         @(negedge Clock);
         k++;
      end while (Busy !== 1'b0 && k < 2000);
      check("pend_idle_seen", Busy, 0);
      @(negedge Clock);
      check("pend_start", LcdStart, 1);
      check("pend_data", LcdData, 8'h80);
      wait_idle("pending", at);
      check("pend_count", n_starts - base, 20);

      // Stray Done in IDLE and in the ISSUE cycle
      base = n_starts;
      tick();
      done_force = 1'b1;
      tick();
      done_force = 1'b0;
      repeat (5) tick();
      check("idle_done_starts", n_starts - base, 0);
      check("idle_done_busy", Busy, 0);
      push_line(8, b);
      tick();
      Update = 1'b1;
      tick();
      Update = 1'b0;
      done_force = 1'b1;
      tick();
      done_force = 1'b0;
      wait_idle("issue_done", at);
      check("issue_done_count", n_starts - base, 10);

      // Randomised redraws with random LCD latency
      for (int i = 0; i < 6; i++) begin
         a = $urandom_range(0, 15);
         b = $urandom_range(0, 15);
         ScoreA = 4'(a);
         ScoreB = 4'(b);
         lcd_delay = $urandom_range(1, 20);
         push_line(a, b);
         base = n_starts;
         pulse_update(q);
         wait_idle("rand_redraw", at);
         check("rand_count", n_starts - base, 10);
      end

      // Done on the timeout cycle counts as completion
      lcd_delay = TO;
      push_line(a, b);
      pulse_update(q);
      wait_idle("edge_done", at);
      check("edge_no_error", Error, 0);

      // Lost transaction: error, then re-init and redraw
      lcd_delay = 0;
      exp_q.push_back({1'b0, 8'h80});
      push_init();
      push_line(a, b);
      pulse_update(q);
      k = q + 1;
      tick();
      lcd_delay = 10;
      while (cyc < k + TO)
         @(negedge Clock);
      check("to_err_before", Error, 0);
      @(negedge Clock);
      check("to_err_set", Error, 1);
      check("to_restart", LcdStart, 1);
      check("to_data", LcdData, 8'h38);
      wait_idle("to_recover", at);
      check("to_err_sticky", Error, 1);

      // Reset during WAIT at step 9, stale Done ignored
      a = $urandom_range(0, 15);
      b = $urandom_range(0, 15);
      ScoreA = 4'(a);
      ScoreB = 4'(b);
      push_line(a, b);
      base = n_starts;
      pulse_update(q);
      wait_starts(base + 6, "reach_step9");
      tick();
      Reset = 1'b1;
      exp_q.delete();
      push_init();
      push_line(a, b);
      @(negedge Clock);
      check("mid_rst_start1", LcdStart, 0);
      tick();
      done_force = 1'b1;
      @(negedge Clock);
      check("mid_rst_start2", LcdStart, 0);
      check("mid_rst_error", Error, 0);
      base = n_starts;
      tick();
      Reset = 1'b0;
      @(negedge Clock);
      check("mid_rel_start", LcdStart, 1);
      check("mid_rel_data", LcdData, 8'h38);
      tick();
      done_force = 1'b0;
      wait_idle("mid_reinit", at);
      check("mid_count", n_starts - base, 14);
      check("mid_error", Error, 0);
      repeat (5) tick();
      check("final_quiet", n_starts - base, 14);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/lcd_score_sequencer.md
# lcd_score_sequencer

Sequencer that owns the LCD character-write unit in the Pong design: after reset it issues the HD44780 initialisation commands, then renders the line "P1:a P2:b" from the two player scores, one byte per Start/Done transaction. Game logic requests a redraw with a one-cycle `Update`. The sequencer serialises these requests, buffers one redraw while busy, and recovers from a stalled LCD unit with a timeout. It sits between the score registers and the LCD write unit, driving that unit's Start, register-select and data inputs and consuming its Done pulse.

## Interface
- `TIMEOUT`, default 300000: number of WAIT cycles without `LcdDone` before a transaction is declared lost. Range 2..1048575; the counter is 20 bits.
- `Clock` in 1: system clock, 50 MHz.
- `Reset` in 1: reset Reset, synchronous, active-high; clock Clock.
- `ScoreA` in 4: player 1 score. Values 10..15 display as '9'.
- `ScoreB` in 4: player 2 score. Same saturation rule as `ScoreA`.
- `Update` in 1: redraw request pulse. Level-sampled each cycle.
- `LcdDone` in 1: one-cycle completion pulse from the LCD write unit.
- `LcdStart` out 1: one-cycle transaction start to the LCD write unit.
- `LcdRS` out 1: register select. 0 = command, 1 = data.
- `LcdData` out 8: byte to write.
- `Busy` out 1: high whenever the FSM is not in IDLE.
- `Error` out 1: sticky timeout flag. Cleared only by `Reset`.

## Operation
- FSM states: ISSUE, WAIT, IDLE.
- Step index: 0..13.
  - Steps 0..3 are init commands with RS=0: 0x38, 0x0C, 0x01, 0x06.
  - Step 4 is 0x80 with RS=0 (line 1 home).
  - Steps 5..13 are data with RS=1: 'P'0x50, '1'0x31, ':'0x3A, digitA, ' '0x20, 'P'0x50, '2'0x32, ':'0x3A, digitB.
- Digit encoding: digit = 0x30 + min(score, 9).
- ISSUE (exactly 1 cycle): `LcdStart`=1. `LcdRS`/`LcdData` take the step's values and hold until the next ISSUE. Next state is WAIT, and the timeout counter clears.
- WAIT, on `LcdDone`:
  - step < 13: step+1 → ISSUE.
  - step = 13: → IDLE.
- WAIT, when the counter reaches `TIMEOUT`-1 without `LcdDone`: `Error`<=1, step<=0 → ISSUE. This is a full re-init followed by an automatic redraw.
- IDLE: if `Update` or pending is set, step<=4 → ISSUE and pending clears.
- Score snapshot: `ScoreA`/`ScoreB` are latched into internal digit registers on every entry to step 4. Inputs changing during steps 5..13 do not affect the current line.
- Init flows directly into steps 4..13, so the initial scores are drawn without an `Update`.

## Timing
- Reset values:
  - `LcdStart`=0, `LcdRS`=0, `LcdData`=0x00, `Error`=0, `Busy`=1.
  - pending=0, step=0, counter=0.
  - State = ISSUE, so the first cycle after `Reset` falls drives `LcdStart`=1 with 0x38.
- `Reset` mid-transaction aborts immediately. No completion pulse is awaited and a stale `LcdDone` is ignored.
- `Update` rules:
  - In any state other than IDLE, `Update` sets pending.
  - Any number of `Update` pulses while busy collapse into one redraw.
  - `Update` coincident with `Reset` is dropped.
- Handshake rules:
  - `LcdDone` is ignored outside WAIT, including in the ISSUE cycle.
  - `LcdStart` never asserts while in WAIT.
- Turnaround latencies:
  - `LcdDone` in WAIT → next `LcdStart` = 1 cycle later.
  - `Update` sampled in IDLE → `LcdStart` with 0x80 on the next cycle.
- Timeout detection occurs exactly `TIMEOUT` cycles after the ISSUE cycle. `LcdDone` arriving on the same cycle as the timeout wins: it counts as completion, with no error.
- `Busy` is registered; it falls in the cycle the FSM enters IDLE.
- The LCD unit's own E-pulse timing (~4 ms/op) covers the 1.52 ms clear-display delay. The sequencer adds no delay of its own.

## Structure
- Package `lcd_seq_pkg`:
  - state encoding;
  - step constants (INIT_LAST=3, HOME=4, LAST=13);
  - command constants CMD_FUNCSET=0x38, CMD_DISPON=0x0C, CMD_CLEAR=0x01, CMD_ENTRY=0x06, CMD_HOME=0x80;
  - ASCII constants.
- Sub-module `lcd_score_rom`: combinational; inputs step[3:0], digitA[7:0], digitB[7:0]; outputs {rs, byte}.
- Top level: FSM, step counter, pending flag, 20-bit timeout counter, score snapshot registers.

## Test plan
- Reset release with an LCD model that returns Done 10 cycles after Start, ScoreA=3, ScoreB=0 → 14 Start pulses carrying 0x38, 0x0C, 0x01, 0x06, 0x80 (RS=0), then 0x50, 0x31, 0x3A, 0x33, 0x20, 0x50, 0x32, 0x3A, 0x30 (RS=1). `Busy` falls 1 cycle after the 14th Done.
- IDLE, ScoreA=7, ScoreB=12, one-cycle `Update` → `LcdStart` with 0x80 on the next cycle. 10 transactions follow, with digits 0x37 and 0x39.
- Three `Update` pulses during step 7, with ScoreA changing 7→8 mid-line:
  - the current line keeps 0x37;
  - exactly one further redraw follows, starting 1 cycle after IDLE is entered, and shows 0x38.
- `TIMEOUT`=50, model never returns Done → `Error`=1 exactly 50 cycles after the ISSUE cycle, then `LcdStart` with 0x38 on the following cycle. `Error` stays 1 through the later successful sequence.
- `Reset` asserted in WAIT at step 9 for 2 cycles:
  - `LcdStart`=0 and `Error`=0 during reset;
  - first cycle after reset: `LcdStart`=1, `LcdData`=0x38;
  - a late `LcdDone` from the aborted transaction is ignored.
- `LcdDone` pulsed in IDLE and in the ISSUE cycle → no extra Start pulses and no step advance.
